// File: rtl/mmio_fifo_pkg.sv
// Shared register map for the mmio_fifo peripheral: register offsets, STATUS and CTRL bit positions.
// Used by the mmio_fifo top; the optional irq feature is selected there with MMIO_FIFO_IRQ_EN.
package mmio_defs;

    localparam logic [1:0] REG_TX_DATA = 2'd0;
    localparam logic [1:0] REG_RX_DATA = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;
    localparam int ST_IRQ_EN   = 6;

    localparam int CTRL_POP    = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_CLR    = 3;

    // The four-register window is BASE..BASE+3; anything wrapping below BASE lands far outside it.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] off;
        off = addr - base;
        return (off[15:2] == 14'd0);
    endfunction

endpackage

// File: rtl/mmio_fifo_sync_fifo.sv
// Single-clock FIFO with flush; DEPTH must be a power of two so the pointers wrap naturally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/mmio_fifo.sv
// Memory-mapped TX/RX FIFO responder on the 8-bit data / 16-bit address CPU bus.
// Define MMIO_FIFO_IRQ_EN to add the o_irq output and the CTRL/STATUS irq-enable bit.
module mmio_fifo
    import mmio_defs::*;
#(
    parameter logic [15:0] BASE  = 16'hFF00,
    parameter int          DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_di,
    input  logic        i_we,
    output logic [7:0]  o_do,
    output logic        o_sel,
`ifdef MMIO_FIFO_IRQ_EN
    output logic        o_irq,
`endif
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready
);

    logic       w_in_win;
    logic [1:0] w_reg;
    logic       w_wr;
    logic       w_rd;
    logic       w_tx_wr;
    logic       w_ctrl_wr;
    logic       w_flush;
    logic       w_pop_req;
    logic       w_clr;
    logic       w_tx_drain;
    logic       w_rx_accept;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;
    logic       w_ovf_set;
    logic       w_unf_set;
    logic [7:0] w_status;
    logic [7:0] w_rd_data;
    logic       r_tx_ovf;
    logic       r_rx_unf;
    logic [7:0] r_do;
    logic       r_sel;
    logic [15:0] w_offset;

    assign w_in_win  = in_window(i_addr, BASE);
    assign w_offset  = i_addr - BASE;
    assign w_reg     = w_offset[1:0];
    assign w_wr      = i_we & w_in_win;
    assign w_rd      = ~i_we & w_in_win;
    assign w_tx_wr   = w_wr & (w_reg == REG_TX_DATA);
    assign w_ctrl_wr = w_wr & (w_reg == REG_CTRL);
    assign w_flush   = w_ctrl_wr & i_di[CTRL_FLUSH];
    assign w_pop_req = w_ctrl_wr & i_di[CTRL_POP];
    assign w_clr     = w_ctrl_wr & i_di[CTRL_CLR];

    assign o_tx_valid  = ~w_tx_empty;
    assign o_rx_ready  = ~w_rx_full;
    assign w_tx_drain  = o_tx_valid & i_tx_ready;
    assign w_rx_accept = i_rx_valid & o_rx_ready;

    // A full TX FIFO still takes the byte if the stream frees a slot in the same cycle.
    assign w_ovf_set = w_tx_wr & w_tx_full & ~w_tx_drain;
    assign w_unf_set = w_pop_req & w_rx_empty & ~w_flush;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_tx_wr),
        .i_pop   (w_tx_drain),
        .i_flush (w_flush),
        .i_data  (i_di),
        .o_head  (o_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rx_accept),
        .i_pop   (w_pop_req),
        .i_flush (w_flush),
        .i_data  (i_rx_data),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

`ifdef MMIO_FIFO_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    assign o_irq = r_irq;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= i_di[CTRL_IRQ_EN];
            end
            r_irq <= r_irq_en & (~w_rx_empty | r_tx_ovf | r_rx_unf);
        end
    end
`else
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{i_di[7:4], i_di[CTRL_IRQ_EN]};
`endif

    always_comb begin
        w_status              = '0;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[ST_RX_UNF]   = r_rx_unf;
`ifdef MMIO_FIFO_IRQ_EN
        w_status[ST_IRQ_EN]   = r_irq_en;
`endif
    end

    always_comb begin
        w_rd_data = '0;
        case (w_reg)
            REG_RX_DATA: w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
            REG_STATUS:  w_rd_data = w_status;
            default:     w_rd_data = '0;
        endcase
    end

    assign o_do  = r_do;
    assign o_sel = r_sel;

    // A set in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_do     <= '0;
            r_sel    <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
        end else begin
            r_sel <= w_rd;
            r_do  <= w_rd ? w_rd_data : 8'h00;
            if (w_ovf_set) begin
                r_tx_ovf <= 1'b1;
            end else if (w_clr) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_rx_unf <= 1'b1;
            end else if (w_clr) begin
                r_rx_unf <= 1'b0;
            end
        end
    end

endmodule
